// File: rtl/bip_core.sv
// bip_core: single-cycle accumulator processor (Basic Instruction Processor).
//
// One instruction per RUN cycle is read from an asynchronous ROM at the PC;
// the operand field doubles as the RAM address. An IDLE/RUN/HALT controller
// gates execution: i_start leaves IDLE or HALT (a HALT restart zeroes the PC
// and keeps the ACC).
//
// Optional feature: define BIP_LOGIC_OPS_EN to enable opcodes 12-19
// (AND, ANDI, OR, ORI, XOR, XORI, SLL, SRL). Undefined, they execute as NOP.
//
// Ports:
//   i_clock     sole clock, rising edge
//   i_reset     synchronous active-low reset
//   i_start     level start/restart request
//   i_Data_rom  instruction at o_Addr_rom (combinational ROM)
//   i_Data_ram  RAM read data at o_Addr_ram (combinational)
//   o_Addr_rom  program counter
//   o_Addr_ram  operand field of the current instruction
//   o_Data_ram  accumulator, RAM write data
//   Wr / Rd     RAM write / read strobes
//   o_halted    high in HALT
//   o_icount    saturating retired-instruction counter
module bip_core #(
  parameter int unsigned BITS   = 16,
  parameter int unsigned OPBITS = 5,
  parameter int unsigned DTBITS = BITS - OPBITS
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [BITS-1:0]   i_Data_rom,
  input  logic [BITS-1:0]   i_Data_ram,
  output logic [DTBITS-1:0] o_Addr_rom,
  output logic [DTBITS-1:0] o_Addr_ram,
  output logic [BITS-1:0]   o_Data_ram,
  output logic              Wr,
  output logic              Rd,
  output logic              o_halted,
  output logic [BITS-1:0]   o_icount
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [OPBITS-1:0] OP_HLT  = OPBITS'(0);
  localparam logic [OPBITS-1:0] OP_STO  = OPBITS'(1);
  localparam logic [OPBITS-1:0] OP_LD   = OPBITS'(2);
  localparam logic [OPBITS-1:0] OP_LDI  = OPBITS'(3);
  localparam logic [OPBITS-1:0] OP_ADD  = OPBITS'(4);
  localparam logic [OPBITS-1:0] OP_ADDI = OPBITS'(5);
  localparam logic [OPBITS-1:0] OP_SUB  = OPBITS'(6);
  localparam logic [OPBITS-1:0] OP_SUBI = OPBITS'(7);
  localparam logic [OPBITS-1:0] OP_JMP  = OPBITS'(8);
  localparam logic [OPBITS-1:0] OP_BEQ  = OPBITS'(9);
  localparam logic [OPBITS-1:0] OP_BNE  = OPBITS'(10);
  localparam logic [OPBITS-1:0] OP_BLT  = OPBITS'(11);
`ifdef BIP_LOGIC_OPS_EN
  localparam logic [OPBITS-1:0] OP_AND  = OPBITS'(12);
  localparam logic [OPBITS-1:0] OP_ANDI = OPBITS'(13);
  localparam logic [OPBITS-1:0] OP_OR   = OPBITS'(14);
  localparam logic [OPBITS-1:0] OP_ORI  = OPBITS'(15);
  localparam logic [OPBITS-1:0] OP_XOR  = OPBITS'(16);
  localparam logic [OPBITS-1:0] OP_XORI = OPBITS'(17);
  localparam logic [OPBITS-1:0] OP_SLL  = OPBITS'(18);
  localparam logic [OPBITS-1:0] OP_SRL  = OPBITS'(19);
`endif

  logic [1:0]        r_state;
  logic [DTBITS-1:0] r_pc;
  logic [BITS-1:0]   r_acc;
  logic [BITS-1:0]   r_icount;

  logic [OPBITS-1:0] w_op;
  logic [DTBITS-1:0] w_opnd;
  logic [BITS-1:0]   w_simm;
  logic [BITS-1:0]   w_acc_nxt;
  logic [DTBITS-1:0] w_pc_nxt;
  logic              w_wr;
  logic              w_rd;
  logic              w_run;
`ifdef BIP_LOGIC_OPS_EN
  logic [BITS-1:0]   w_zimm;
`endif

  assign w_op   = i_Data_rom[BITS-1 -: OPBITS];
  assign w_opnd = i_Data_rom[DTBITS-1:0];
  assign w_simm = {{(BITS-DTBITS){w_opnd[DTBITS-1]}}, w_opnd};
`ifdef BIP_LOGIC_OPS_EN
  assign w_zimm = {{(BITS-DTBITS){1'b0}}, w_opnd};
`endif

  // Strobes are qualified by reset so an instruction caught by reset never writes RAM.
  assign w_run      = i_reset && (r_state == S_RUN);
  assign Wr         = w_run && w_wr;
  assign Rd         = w_run && w_rd;
  assign o_Addr_rom = r_pc;
  assign o_Addr_ram = w_opnd;
  assign o_Data_ram = r_acc;
  assign o_halted   = (r_state == S_HALT);
  assign o_icount   = r_icount;

  always_comb begin
    w_acc_nxt = r_acc;
    w_pc_nxt  = r_pc + DTBITS'(1);
    w_wr      = 1'b0;
    w_rd      = 1'b0;
    case (w_op)
      OP_HLT:  w_pc_nxt = r_pc;
      OP_STO:  w_wr = 1'b1;
      OP_LD:   begin w_rd = 1'b1; w_acc_nxt = i_Data_ram; end
      OP_LDI:  w_acc_nxt = w_simm;
      OP_ADD:  begin w_rd = 1'b1; w_acc_nxt = r_acc + i_Data_ram; end
      OP_ADDI: w_acc_nxt = r_acc + w_simm;
      OP_SUB:  begin w_rd = 1'b1; w_acc_nxt = r_acc - i_Data_ram; end
      OP_SUBI: w_acc_nxt = r_acc - w_simm;
      OP_JMP:  w_pc_nxt = w_opnd;
      OP_BEQ:  if (r_acc == '0) w_pc_nxt = w_opnd;
      OP_BNE:  if (r_acc != '0) w_pc_nxt = w_opnd;
      OP_BLT:  if (r_acc[BITS-1]) w_pc_nxt = w_opnd;
`ifdef BIP_LOGIC_OPS_EN
      OP_AND:  begin w_rd = 1'b1; w_acc_nxt = r_acc & i_Data_ram; end
      OP_ANDI: w_acc_nxt = r_acc & w_zimm;
      OP_OR:   begin w_rd = 1'b1; w_acc_nxt = r_acc | i_Data_ram; end
      OP_ORI:  w_acc_nxt = r_acc | w_zimm;
      OP_XOR:  begin w_rd = 1'b1; w_acc_nxt = r_acc ^ i_Data_ram; end
      OP_XORI: w_acc_nxt = r_acc ^ w_zimm;
      OP_SLL:  w_acc_nxt = r_acc << w_opnd[3:0];
      OP_SRL:  w_acc_nxt = r_acc >> w_opnd[3:0];
`endif
      default: ; // undefined opcodes retire as NOP
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_acc    <= '0;
      r_icount <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) r_state <= S_RUN;
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_pc  <= w_pc_nxt;
          if (r_icount != '1) r_icount <= r_icount + BITS'(1);
          if (w_op == OP_HLT) r_state <= S_HALT;
        end
        S_HALT: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_pc    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_core.sv
// Testbench for bip_core: directed programs plus a random program run, each
// cycle compared with an instruction-level interpreter of the processor.
module tb_bip_core;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] rom_data, ram_data;
  logic [10:0] addr_rom, addr_ram;
  logic [15:0] data_ram, icount;
  logic        wr, rd, halted;

  logic [15:0] rom [2048];
  logic [15:0] ram [2048];

  // Reference model state
  int m_mode, m_pc, m_acc, m_icnt;
  int m_ram [2048];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[addr_rom];
  assign ram_data = ram[addr_ram];

  always @(posedge clk) if (wr) ram[addr_ram] <= data_ram;

  bip_core dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_Data_rom (rom_data),
    .i_Data_ram (ram_data),
    .o_Addr_rom (addr_rom),
    .o_Addr_ram (addr_ram),
    .o_Data_ram (data_ram),
    .Wr         (wr),
    .Rd         (rd),
    .o_halted   (halted),
    .o_icount   (icount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int opnd);
    return 16'((op << 11) | (opnd & 'h7FF));
  endfunction

  function automatic bit logic_ops_on();
`ifdef BIP_LOGIC_OPS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  task automatic sync_mem();
    for (int i = 0; i < 2048; i++) m_ram[i] = int'(ram[i]);
  endtask

  // Interpret one clock edge at the instruction level.
  task automatic model_edge(input logic rst_n, input logic start);
    int op, opnd, simm, mem, acc;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = 0; m_acc = 0; m_icnt = 0;
      return;
    end
    if (m_mode == M_IDLE) begin
      if (start) m_mode = M_RUN;
      return;
    end
    if (m_mode == M_HALT) begin
      if (start) begin m_mode = M_RUN; m_pc = 0; end
      return;
    end
    op   = int'(rom[m_pc]) / 2048;
    opnd = int'(rom[m_pc]) % 2048;
    simm = (opnd >= 1024) ? opnd - 2048 : opnd;
    mem  = m_ram[opnd];
    acc  = m_acc;
    m_pc = (m_pc + 1) % 2048;
    case (op)
      0:  begin m_pc = (m_pc + 2047) % 2048; m_mode = M_HALT; end
      1:  m_ram[opnd] = acc;
      2:  acc = mem;
      3:  acc = simm;
      4:  acc = acc + mem;
      5:  acc = acc + simm;
      6:  acc = acc - mem;
      7:  acc = acc - simm;
      8:  m_pc = opnd;
      9:  if (acc == 0) m_pc = opnd;
      10: if (acc != 0) m_pc = opnd;
      11: if (acc >= 32768) m_pc = opnd;
      default: begin
        if (logic_ops_on()) begin
          case (op)
            12: acc = acc & mem;
            13: acc = acc & opnd;
            14: acc = acc | mem;
            15: acc = acc | opnd;
            16: acc = acc ^ mem;
            17: acc = acc ^ opnd;
            18: acc = acc * (1 << (opnd % 16));
            19: acc = acc / (1 << (opnd % 16));
            default: ;
          endcase
        end
      end
    endcase
    m_acc = acc & 'hFFFF;
    if (m_icnt < 65535) m_icnt++;
  endtask

  task automatic check_outputs(input logic rst_n);
    int op, exp_wr, exp_rd;
    op = int'(rom[m_pc]) / 2048;
    exp_wr = (rst_n && m_mode == M_RUN && op == 1) ? 1 : 0;
    exp_rd = (rst_n && m_mode == M_RUN &&
              (op == 2 || op == 4 || op == 6 ||
               (logic_ops_on() && (op == 12 || op == 14 || op == 16)))) ? 1 : 0;
    check("pc", 32'(addr_rom), 32'(m_pc));
    check("acc", 32'(data_ram), 32'(m_acc));
    check("icount", 32'(icount), 32'(m_icnt));
    check("halted", 32'(halted), (m_mode == M_HALT) ? 1 : 0);
    check("addr_ram", 32'(addr_ram), 32'(int'(rom[m_pc]) % 2048));
    check("wr", 32'(wr), 32'(exp_wr));
    check("rd", 32'(rd), 32'(exp_rd));
  endtask

  // Called at a negedge: drive inputs, check, advance one edge, return at negedge.
  task automatic step(input logic rst_n, input logic start);
    i_reset = rst_n;
    i_start = start;
    #1;
    check_outputs(rst_n);
    @(posedge clk);
    model_edge(rst_n, start);
    @(negedge clk);
  endtask

  task automatic boot(input int run_cycles);
    sync_mem();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (run_cycles) step(1'b1, 1'b0);
  endtask

  initial begin
    int nbad;
    logic rst_n, start;
    @(negedge clk);

    // Basic program: 3 + 2 - RAM[1] then halt
    clear_mem();
    rom[0] = ins(3, 3); rom[1] = ins(5, 2); rom[2] = ins(6, 1); rom[3] = ins(0, 0);
    ram[1] = 16'h0001;
    boot(4);
    check("p1_acc", 32'(data_ram), 32'h0004);
    check("p1_halted", 32'(halted), 1);
    check("p1_icount", 32'(icount), 4);
    check("p1_pc", 32'(addr_rom), 3);
    step(1'b1, 1'b0);
    check("p1_halt_hold", 32'(addr_rom), 3);
    step(1'b1, 1'b1);  // restart from HALT: PC=0, ACC kept
    check("p1_restart_pc", 32'(addr_rom), 0);
    check("p1_restart_acc", 32'(data_ram), 32'h0004);
    repeat (4) step(1'b1, 1'b0);

    // Sign-extended load then BLT
    clear_mem();
    rom[0] = ins(3, 'h7FF); rom[1] = ins(11, 'h010);
    boot(2);
    check("blt_acc", 32'(data_ram), 32'hFFFF);
    check("blt_pc", 32'(addr_rom), 32'h010);

    // BEQ / BNE
    clear_mem();
    rom[0] = ins(3, 0); rom[1] = ins(9, 5); rom[2] = ins(10, 0);
    rom[5] = ins(3, 1); rom[6] = ins(10, 0);
    boot(2);
    check("beq_pc", 32'(addr_rom), 5);
    repeat (2) step(1'b1, 1'b0);
    check("bne_pc", 32'(addr_rom), 0);

    // PC wrap through undefined opcode 31 at the top address
    clear_mem();
    rom[0] = ins(8, 'h7FF); rom['h7FF] = ins(31, 0);
    boot(1);
    check("wrap_at_top", 32'(addr_rom), 32'h7FF);
    step(1'b1, 1'b0);
    check("wrap_pc", 32'(addr_rom), 0);
    check("wrap_icount", 32'(icount), 2);

    // STO, then reset during the STO cycle
    clear_mem();
    rom[0] = ins(2, 7); rom[1] = ins(1, 2); ram[7] = 16'h1234;
    boot(1);
    i_reset = 1'b1; i_start = 1'b0; #1;
    check("sto_wr", 32'(wr), 1);
    check("sto_addr", 32'(addr_ram), 2);
    check("sto_data", 32'(data_ram), 32'h1234);
    i_reset = 1'b0; #1;
    check("sto_rst_wr", 32'(wr), 0);
    @(posedge clk);
    model_edge(1'b0, 1'b0);
    @(negedge clk);
    check("sto_rst_acc", 32'(data_ram), 0);
    check("sto_rst_ram", 32'(ram[2]), 0);

    // ANDI (logic op or NOP depending on build)
    clear_mem();
    rom[0] = ins(3, 'h0AB); rom[1] = ins(13, 'h00F);
    boot(2);
    check("andi_acc", 32'(data_ram), logic_ops_on() ? 32'h000B : 32'h00AB);
    check("andi_icount", 32'(icount), 2);

    // Random program with random RAM, occasional resets and restarts
    for (int i = 0; i < 2048; i++) begin
      rom[i] = 16'($urandom);
      ram[i] = 16'($urandom);
    end
    boot(0);
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 3) == 0);
      step(rst_n, start);
    end
    nbad = 0;
    for (int i = 0; i < 2048; i++) if (int'(ram[i]) != m_ram[i]) nbad++;
    check("ram_image", 32'(nbad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
